// File: rtl/cla_pkg.sv
// Shared definitions for the multi-precision CLA sequencer.
//   WORD_W       limb width handled by one CLA_32 pass
//   MAX_WORDS    largest supported limb count
//   MAX_OP_W     widest operand vector limb_sel accepts
//   LIMB_IDX_W   index width wide enough for MAX_WORDS limbs
//   state_t      sequencer FSM encoding (IDLE / RUN)
//   limb_sel()   extracts limb idx from a zero-extended operand vector
package cla_pkg;

    localparam int WORD_W     = 32;
    localparam int MAX_WORDS  = 16;
    localparam int MAX_OP_W   = MAX_WORDS * WORD_W;
    localparam int LIMB_IDX_W = $clog2(MAX_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Callers zero-extend their operand to MAX_OP_W so a single function
    // serves every WORDS setting.
    function automatic logic [WORD_W-1:0] limb_sel(
        input logic [MAX_OP_W-1:0]   vec,
        input logic [LIMB_IDX_W-1:0] idx
    );
        return vec[idx*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/cla_mp_sequencer_cla32.sv
// CLA_32: 32-bit carry-lookahead adder, purely combinational.
//   x, y   in   32   addends
//   cin    in   1    carry in
//   sum    out  32   x + y + cin (mod 2^32)
//   cout   out  1    carry out of bit 31
// Bits are grouped in 4-bit blocks; each block produces group generate /
// propagate, group carries are resolved from those, and bit carries inside a
// block are derived from the block's incoming carry.
module cla_32
    import cla_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    input  logic [WORD_W-1:0] y,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    localparam int GRP_W = 4;
    localparam int NGRP  = WORD_W / GRP_W;

    logic [WORD_W-1:0] g;
    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] c;
    logic [NGRP-1:0]   gg;
    logic [NGRP-1:0]   gp;
    logic [NGRP:0]     gc;

    always_comb begin
        g  = x & y;
        p  = x ^ y;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;

        gc[0] = cin;
        for (int j = 0; j < NGRP; j++) begin
            gp[j] = &p[j*GRP_W +: GRP_W];
            // Fold from LSB upward: gg = g3 | p3&(g2 | p2&(g1 | p1&g0)).
            for (int k = 0; k < GRP_W; k++) begin
                gg[j] = g[j*GRP_W+k] | (p[j*GRP_W+k] & gg[j]);
            end
            gc[j+1] = gg[j] | (gp[j] & gc[j]);
        end

        for (int j = 0; j < NGRP; j++) begin
            for (int k = 0; k < GRP_W; k++) begin
                if (k == 0) begin
                    c[j*GRP_W] = gc[j];
                end else begin
                    c[j*GRP_W+k] = g[j*GRP_W+k-1] | (p[j*GRP_W+k-1] & c[j*GRP_W+k-1]);
                end
            end
        end

        sum  = p ^ c;
        cout = gc[NGRP];
    end

endmodule

// File: rtl/cla_mp_sequencer.sv
// cla_mp_sequencer: multi-precision add/subtract controller that runs one
// CLA_32 over WORDS 32-bit limbs, least-significant limb first, chaining the
// carry through a register.
//   clk     in   1          rising-edge clock
//   rst     in   1          asynchronous reset, active-high
//   start   in   1          request, accepted only while idle
//   sub     in   1          0: a+b, 1: a-b (sampled with start)
//   a, b    in   WORDS*32   operands (sampled with start)
//   busy    out  1          high while limbs are being processed
//   done    out  1          one-cycle pulse, result/cout/ovf valid from here on
//   result  out  WORDS*32   sum / difference
//   cout    out  1          carry out of the top limb (sub: 1 = no borrow)
//   ovf     out  1          signed overflow of the full-width operation
module cla_mp_sequencer
    import cla_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    sub,
    input  logic [WORDS*WORD_W-1:0] a,
    input  logic [WORDS*WORD_W-1:0] b,
    output logic                    busy,
    output logic                    done,
    output logic [WORDS*WORD_W-1:0] result,
    output logic                    cout,
    output logic                    ovf
);

    localparam int OP_W  = WORDS * WORD_W;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    if (WORDS < 2 || WORDS > MAX_WORDS) begin : g_bad_words
        $error("cla_mp_sequencer: WORDS must be within 2..16");
    end

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              carry;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic              sub_reg;
    logic [MAX_OP_W-1:0] a_ext;
    logic [MAX_OP_W-1:0] b_ext;
    logic [WORD_W-1:0] b_limb;
    logic [WORD_W-1:0] cla_x;
    logic [WORD_W-1:0] cla_y;
    logic [WORD_W-1:0] cla_sum;
    logic              cla_cout;
    logic              accept;
    logic              last;
    logic              ovf_nxt;

    assign accept = (state == IDLE) && start;
    assign last   = (idx == LAST_IDX);

    // Limb mux: in IDLE idx just points at stale operand data, which nothing
    // downstream observes.
    assign a_ext  = MAX_OP_W'(a_reg);
    assign b_ext  = MAX_OP_W'(b_reg);
    assign cla_x  = limb_sel(a_ext, LIMB_IDX_W'(idx));
    assign b_limb = limb_sel(b_ext, LIMB_IDX_W'(idx));
    // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
    assign cla_y  = sub_reg ? ~b_limb : b_limb;

    // Signed overflow: operands agree in sign but the sum does not.
    assign ovf_nxt = (cla_x[WORD_W-1] == cla_y[WORD_W-1]) &&
                     (cla_sum[WORD_W-1] != cla_x[WORD_W-1]);

    cla_32 u_cla (
        .x    (cla_x),
        .y    (cla_y),
        .cin  (carry),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state == RUN);
    end

    // Operand capture; contents are only meaningful during RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg   <= a;
            b_reg   <= b;
            sub_reg <= sub;
        end
    end

    // Limb sequencing, carry chain and completion flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            carry  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                idx   <= '0;
                carry <= sub;
            end else if (state == RUN) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (idx == IDX_W'(k)) begin
                        result[k*WORD_W +: WORD_W] <= cla_sum;
                    end
                end
                carry <= cla_cout;
                idx   <= idx + 1'b1;
                // cout/ovf change only on the edge that raises done.
                if (last) begin
                    done <= 1'b1;
                    cout <= cla_cout;
                    ovf  <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_mp_sequencer.sv
module tb_cla_mp_sequencer;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic         sub   = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    cla_mp_sequencer #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    // Full-width reference: one wide addition, no limbs.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
        logic [W:0]   full;
        logic [W-1:0] bb;
        exp_t         r;
        bb    = ms ? ~mb : mb;
        full  = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, ms};
        r.res = full[W-1:0];
        r.co  = full[W];
        r.ov  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle and queue its expected outcome; returns in cycle 1.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input exp_t e);
        sbq.push_back(e);
        a     = ta;
        b     = tb;
        sub   = ts;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Advance until done (bounded); lat is the cycle index relative to the start cycle.
    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (done !== 1'b1 && lat < 16) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        int   lat;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, cout, ovf} !== 4'b0000 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_initial: got busy=%b done=%b cout=%b ovf=%b result=%h, want all zero",
                     busy, done, cout, ovf, result);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        step();

        issue(W'(7), W'(5), 1'b1, model(W'(7), W'(5), 1'b1));
        wait_done(1, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
            miscompares++;
            $display("FAIL reset_preop: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                     lat, result, cout, ovf, e.res, e.co, e.ov);
        end

        // Asynchronous reset between clock edges.
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, cout, ovf} !== 4'b0000 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got busy=%b done=%b cout=%b ovf=%b result=%h, want all zero",
                     busy, done, cout, ovf, result);
        end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_carry_wrap();
        exp_t e;
        issue({W{1'b1}}, W'(1), 1'b0, '{res: '0, co: 1'b1, ov: 1'b0});
        for (int c = 1; c <= 4; c++) begin
            vectors++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL wrap_busy_c%0d: got busy=%b done=%b, want busy=1 done=0", c, busy, done);
            end
            step();
        end
        e = sbq.pop_front();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
            miscompares++;
            $display("FAIL wrap_done: got done=%b busy=%b result=%h cout=%b ovf=%b, want done=1 busy=0 result=%h cout=%b ovf=%b",
                     done, busy, result, cout, ovf, e.res, e.co, e.ov);
        end
        step();
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_done_pulse: got done=%b in cycle 6, want 0", done);
        end
    endtask

    task automatic test_carry_chain();
        exp_t e;
        int   lat;
        issue(W'(32'hFFFF_FFFF), W'(1), 1'b0, '{res: W'(64'h1_0000_0000), co: 1'b0, ov: 1'b0});
        wait_done(1, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
            miscompares++;
            $display("FAIL carry_chain: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                     lat, result, cout, ovf, e.res, e.co, e.ov);
        end
        step();
    endtask

    task automatic test_subtract();
        logic [W-1:0] ta[2];
        logic [W-1:0] tb[2];
        exp_t         te[2];
        exp_t         e;
        int           lat;
        ta[0] = W'(5); tb[0] = W'(7); te[0] = '{res: {{(W-1){1'b1}}, 1'b0}, co: 1'b0, ov: 1'b0};
        ta[1] = W'(7); tb[1] = W'(5); te[1] = '{res: W'(2), co: 1'b1, ov: 1'b0};
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i], 1'b1, te[i]);
            wait_done(1, lat);
            e = sbq.pop_front();
            vectors++;
            if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
                miscompares++;
                $display("FAIL subtract_%0d: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                         i, lat, result, cout, ovf, e.res, e.co, e.ov);
            end
            step();
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] ta[2];
        logic [W-1:0] tb[2];
        logic         ts[2];
        exp_t         te[2];
        exp_t         e;
        int           lat;
        ta[0] = {1'b0, {(W-1){1'b1}}}; tb[0] = W'(1); ts[0] = 1'b0;
        te[0] = '{res: {1'b1, {(W-1){1'b0}}}, co: 1'b0, ov: 1'b1};
        ta[1] = {1'b1, {(W-1){1'b0}}}; tb[1] = W'(1); ts[1] = 1'b1;
        te[1] = '{res: {1'b0, {(W-1){1'b1}}}, co: 1'b1, ov: 1'b1};
        for (int i = 0; i < 2; i++) begin
            issue(ta[i], tb[i], ts[i], te[i]);
            if (i == 1) begin
                // Flags from the previous op must hold while this one runs.
                step();
                vectors++;
                if (cout !== 1'b0 || ovf !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovf_hold: got cout=%b ovf=%b in cycle 2, want cout=0 ovf=1", cout, ovf);
                end
                wait_done(2, lat);
            end else begin
                wait_done(1, lat);
            end
            e = sbq.pop_front();
            vectors++;
            if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
                miscompares++;
                $display("FAIL overflow_%0d: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                         i, lat, result, cout, ovf, e.res, e.co, e.ov);
            end
            step();
        end
    endtask

    task automatic test_handshake();
        exp_t         e;
        int           lat;
        logic [W-1:0] xa;
        logic [W-1:0] xb;
        xa = {4{32'h1234_5678}};
        xb = {4{32'h0F0F_0F0F}};
        issue(xa, xb, 1'b0, model(xa, xb, 1'b0));
        step();
        // Cycle 2 of the run: this start and its operands must be ignored.
        a     = {W{1'b1}};
        b     = {W{1'b1}};
        sub   = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(3, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
            miscompares++;
            $display("FAIL ignore_start: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                     lat, result, cout, ovf, e.res, e.co, e.ov);
        end
        // Start in the done cycle is accepted.
        issue(xb, xa, 1'b1, model(xb, xa, 1'b1));
        wait_done(1, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
            miscompares++;
            $display("FAIL back_to_back: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                     lat, result, cout, ovf, e.res, e.co, e.ov);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        exp_t         e;
        int           lat;
        logic         seen;
        logic [W-1:0] xa;
        xa = {4{32'hDEAD_BEEF}};
        // Abandoned op: nothing queued for it.
        a     = xa;
        b     = W'(3);
        sub   = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done, cout, ovf} !== 4'b0000 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_midrun: got busy=%b done=%b cout=%b ovf=%b result=%h, want all zero",
                     busy, done, cout, ovf, result);
        end
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_no_done: got done pulse after abort, want none");
        end
        issue(xa, W'(3), 1'b0, model(xa, W'(3), 1'b0));
        wait_done(1, lat);
        e = sbq.pop_front();
        vectors++;
        if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
            miscompares++;
            $display("FAIL reset_recover: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                     lat, result, cout, ovf, e.res, e.co, e.ov);
        end
        step();
    endtask

    task automatic test_random();
        exp_t         e;
        int           lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        rs = 1'($urandom_range(0, 1));
        issue(ra, rb, rs, model(ra, rb, rs));
        for (int i = 0; i < 8; i++) begin
            wait_done(1, lat);
            e = sbq.pop_front();
            vectors++;
            if (lat !== 5 || result !== e.res || cout !== e.co || ovf !== e.ov) begin
                miscompares++;
                $display("FAIL random_%0d: got lat=%0d result=%h cout=%b ovf=%b, want lat=5 result=%h cout=%b ovf=%b",
                         i, lat, result, cout, ovf, e.res, e.co, e.ov);
            end
            if (i < 7) begin
                ra = {$urandom, $urandom, $urandom, $urandom};
                rb = {$urandom, $urandom, $urandom, $urandom};
                rs = 1'($urandom_range(0, 1));
                issue(ra, rb, rs, model(ra, rb, rs));
            end
        end
        step();
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_carry_chain();
        test_subtract();
        test_overflow();
        test_handshake();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
